// File: rtl/jtype_jump_unit.sv
// jtype_jump_unit
//   Execute-stage jump-target unit for JAL/JALR. It computes pc + imm, masks bit 0 for JALR,
//   and flags a misaligned target. Results are registered, so there is exactly one cycle of
//   latency and no combinational path from inputs to outputs.
// Ports
//   i_clk          clock, rising edge
//   i_reset        synchronous active-high reset; takes priority over i_en
//   i_en           1 = capture a new result, 0 = hold (stall)
//   i_pc           JAL: instruction PC; JALR: rs1 base value
//   i_imm          sign-extended immediate
//   i_alu_select   operation select code
//   o_next_pc      registered jump target
//   o_jump_taken   registered; 1 when o_next_pc holds a JAL/JALR target
//   o_misaligned   registered; 1 when the target breaks instruction alignment
module jtype_jump_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [5:0]  SEL_JAL  = 6'b000011,
  parameter logic [5:0]  SEL_JALR = 6'b000100,
  parameter bit          C_EXT    = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [5:0]      i_alu_select,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_jump_taken,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_target;
  logic            w_taken;
  logic            w_mis;

  logic [XLEN-1:0] r_next_pc;
  logic            r_jump_taken;
  logic            r_misaligned;

  // Adder wraps modulo 2^XLEN; no overflow indication is needed for address arithmetic.
  assign w_sum = i_pc + i_imm;

  always_comb begin
    w_target = '0;
    w_taken  = 1'b0;
    // Unknown or unsupported codes fall through to the no-jump default.
    case (i_alu_select)
      SEL_JAL: begin
        w_target = w_sum;
        w_taken  = 1'b1;
      end
      SEL_JALR: begin
        w_target = {w_sum[XLEN-1:1], 1'b0};
        w_taken  = 1'b1;
      end
      default: begin
        w_target = '0;
        w_taken  = 1'b0;
      end
    endcase
  end

  // Compressed ISA only needs halfword alignment; otherwise targets must be word aligned.
  always_comb begin
    w_mis = 1'b0;
    if (w_taken) begin
      if (C_EXT) begin
        w_mis = w_target[0];
      end else begin
        w_mis = |w_target[1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_next_pc    <= '0;
      r_jump_taken <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (i_en) begin
      r_next_pc    <= w_target;
      r_jump_taken <= w_taken;
      r_misaligned <= w_mis;
    end
  end

  assign o_next_pc    = r_next_pc;
  assign o_jump_taken = r_jump_taken;
  assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_jtype_jump_unit.sv
// tb_jtype_jump_unit
//   Directed bench for jtype_jump_unit. A 4-byte-aligned instance (C_EXT=0) is the main DUT;
//   a second instance with C_EXT=1 shares its inputs to cover the halfword-alignment rule.
module tb_jtype_jump_unit;

  localparam logic [5:0] SelJal  = 6'b000011;
  localparam logic [5:0] SelJalr = 6'b000100;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [5:0]  sel;

  logic [31:0] next_pc;
  logic        taken;
  logic        mis;
  logic [31:0] next_pc_c;
  logic        taken_c;
  logic        mis_c;

  int n_checks;
  int n_fail;

  jtype_jump_unit #(
    .XLEN     (32),
    .SEL_JAL  (SelJal),
    .SEL_JALR (SelJalr),
    .C_EXT    (1'b0)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (en),
    .i_pc         (pc),
    .i_imm        (imm),
    .i_alu_select (sel),
    .o_next_pc    (next_pc),
    .o_jump_taken (taken),
    .o_misaligned (mis)
  );

  jtype_jump_unit #(
    .XLEN     (32),
    .SEL_JAL  (SelJal),
    .SEL_JALR (SelJalr),
    .C_EXT    (1'b1)
  ) dut_c (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (en),
    .i_pc         (pc),
    .i_imm        (imm),
    .i_alu_select (sel),
    .o_next_pc    (next_pc_c),
    .o_jump_taken (taken_c),
    .o_misaligned (mis_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [5:0] s,
                      input logic [31:0] p, input logic [31:0] i);
    reset = r;
    en    = e;
    sel   = s;
    pc    = p;
    imm   = i;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, SelJal, 32'd100, 32'd20);
    n_checks++;
    if (next_pc !== 32'd0 || taken !== 1'b0 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got %h/%b/%b, want 00000000/0/0", next_pc, taken, mis);
    end
  endtask

  task automatic test_jal();
    step(1'b0, 1'b1, SelJal, 32'd100, 32'd20);
    n_checks++;
    if (next_pc !== 32'd120 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL jal: got %0d/%b/%b, want 120/1/0", next_pc, taken, mis);
    end
    step(1'b0, 1'b1, SelJal, 32'd200, -32'sd40);
    n_checks++;
    if (next_pc !== 32'd160 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_neg: got %0d/%b/%b, want 160/1/0", next_pc, taken, mis);
    end
  endtask

  task automatic test_jalr();
    step(1'b0, 1'b1, SelJalr, 32'd300, 32'd15);
    n_checks++;
    if (next_pc !== 32'd314 || taken !== 1'b1 || mis !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr_mis: got %0d/%b/%b, want 314/1/1", next_pc, taken, mis);
    end
    // 314 is halfword aligned, so the compressed-ISA instance must not flag it.
    n_checks++;
    if (next_pc_c !== 32'd314 || mis_c !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_cext: got %0d/%b, want 314/0", next_pc_c, mis_c);
    end
    step(1'b0, 1'b1, SelJalr, 32'd1023, 32'd5);
    n_checks++;
    if (next_pc !== 32'd1028 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_odd: got %0d/%b/%b, want 1028/1/0", next_pc, taken, mis);
    end
  endtask

  task automatic test_alignment();
    // JAL keeps bit 0: odd target is misaligned under both alignment rules.
    step(1'b0, 1'b1, SelJal, 32'd101, 32'd0);
    n_checks++;
    if (next_pc !== 32'd101 || mis !== 1'b1 || mis_c !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_odd: got %0d/%b/%b, want 101/1/1", next_pc, mis, mis_c);
    end
    step(1'b0, 1'b1, SelJal, 32'd100, 32'd2);
    n_checks++;
    if (next_pc !== 32'd102 || mis !== 1'b1 || mis_c !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_half: got %0d/%b/%b, want 102/1/0", next_pc, mis, mis_c);
    end
  endtask

  task automatic test_default();
    step(1'b0, 1'b1, 6'b111111, 32'd500, 32'd100);
    n_checks++;
    if (next_pc !== 32'd0 || taken !== 1'b0 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL default: got %0d/%b/%b, want 0/0/0", next_pc, taken, mis);
    end
    // Near-miss codes next to the jump encodings, with an odd sum that would flag misaligned.
    step(1'b0, 1'b1, SelJal, 32'd8, 32'd8);
    step(1'b0, 1'b1, 6'b000111, 32'd3, 32'd0);
    n_checks++;
    if (next_pc !== 32'd0 || taken !== 1'b0 || mis !== 1'b0 || mis_c !== 1'b0) begin
      n_fail++;
      $display("FAIL near_miss: got %0d/%b/%b/%b, want 0/0/0/0", next_pc, taken, mis, mis_c);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, SelJal, 32'd100, 32'd20);
    step(1'b0, 1'b0, 6'b111111, 32'd500, 32'd100);
    n_checks++;
    if (next_pc !== 32'd120 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL stall: got %0d/%b/%b, want 120/1/0", next_pc, taken, mis);
    end
    step(1'b0, 1'b0, SelJalr, 32'd300, 32'd15);
    n_checks++;
    if (next_pc !== 32'd120 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL stall2: got %0d/%b/%b, want 120/1/0", next_pc, taken, mis);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b0, 1'b1, SelJalr, 32'd300, 32'd15);
    step(1'b1, 1'b1, SelJalr, 32'd300, 32'd15);
    n_checks++;
    if (next_pc !== 32'd0 || taken !== 1'b0 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %0d/%b/%b, want 0/0/0", next_pc, taken, mis);
    end
    step(1'b0, 1'b1, SelJal, 32'd100, 32'd20);
    n_checks++;
    if (next_pc !== 32'd120 || taken !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset: got %0d/%b, want 120/1", next_pc, taken);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, SelJal, 32'hFFFF_FFFC, 32'd8);
    n_checks++;
    if (next_pc !== 32'd4 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got %h/%b/%b, want 00000004/1/0", next_pc, taken, mis);
    end
  endtask

  task automatic test_latency();
    step(1'b0, 1'b1, SelJal, 32'd1000, 32'd24);
    // New inputs with no edge must not reach the outputs.
    sel = SelJalr;
    pc  = 32'd7;
    imm = 32'd0;
    #3;
    n_checks++;
    if (next_pc !== 32'd1024 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL no_comb_path: got %0d/%b, want 1024/0", next_pc, mis);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, SelJalr, 32'd64, 32'd3);
    n_checks++;
    if (next_pc !== 32'd66 || mis !== 1'b1 || mis_c !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_0: got %0d/%b/%b, want 66/1/0", next_pc, mis, mis_c);
    end
    step(1'b0, 1'b1, SelJal, 32'h8000_0000, 32'hFFFF_FFF0);
    n_checks++;
    if (next_pc !== 32'h7FFF_FFF0 || taken !== 1'b1 || mis !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_1: got %h/%b/%b, want 7ffffff0/1/0", next_pc, taken, mis);
    end
    step(1'b0, 1'b1, 6'b000000, 32'd12, 32'd4);
    n_checks++;
    if (next_pc !== 32'd0 || taken !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_2: got %0d/%b, want 0/0", next_pc, taken);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    en       = 1'b0;
    sel      = 6'b0;
    pc       = 32'd0;
    imm      = 32'd0;
    #2;
    test_reset();
    test_jal();
    test_jalr();
    test_alignment();
    test_default();
    test_stall();
    test_reset_midstream();
    test_wrap();
    test_latency();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
